// File: rtl/merge_node_ctrl_if.sv
// merge_node_ctrl_if: FIFO-head, strobe and status bundle for one merge-tree node
interface merge_node_ctrl_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int COUNT_WIDTH = 16
);
   logic                   start;
   logic [DATA_WIDTH-1:0]  a_item;
   logic                   a_empty;
   logic                   a_read;
   logic [DATA_WIDTH-1:0]  b_item;
   logic                   b_empty;
   logic                   b_read;
   logic [DATA_WIDTH-1:0]  item;
   logic                   write;
   logic                   out_full;
   logic                   busy;
   logic                   done;
   logic [COUNT_WIDTH-1:0] count;
   modport master (
      input  start, a_item, a_empty, b_item, b_empty, out_full,
      output a_read, b_read, item, write, busy, done, count
   );
   modport slave (
      output start, a_item, a_empty, b_item, b_empty, out_full,
      input  a_read, b_read, item, write, busy, done, count
   );
endinterface

// File: rtl/merge_node_ctrl.sv
// merge_node_ctrl: two-way sorted merge sequencer; define MERGE_DESCENDING_EN for descending order
module merge_node_ctrl #(
   parameter int DATA_WIDTH  = 64,
   parameter int KEY_WIDTH   = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   merge_node_ctrl_if.master       bus
);
   typedef enum logic [2:0] {IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH, DONE} state_t;
   state_t                 state;
   logic                   busy, done;
   logic [COUNT_WIDTH-1:0] count;
   logic [KEY_WIDTH-1:0]   key_a, key_b;
   logic                   a_term, b_term, a_first;
   logic                   merge_go, drain_a_go, drain_b_go, flush_go;
   logic                   a_rd, b_rd, wr, push_data;
   logic [DATA_WIDTH-1:0]  item;
   assign key_a = bus.a_item[DATA_WIDTH-1 -: KEY_WIDTH];
   assign key_b = bus.b_item[DATA_WIDTH-1 -: KEY_WIDTH];
   assign a_term = bus.a_item == '0;
   assign b_term = bus.b_item == '0;
`ifdef MERGE_DESCENDING_EN
   assign a_first = key_a >= key_b;
`else
   assign a_first = key_a <= key_b;
`endif
   assign merge_go   = state == MERGE && !bus.a_empty && !bus.b_empty && !bus.out_full;
   assign drain_a_go = state == DRAIN_A && !bus.a_empty && !bus.out_full;
   assign drain_b_go = state == DRAIN_B && !bus.b_empty && !bus.out_full;
   assign flush_go   = state == FLUSH && !bus.out_full;
   // A lone terminator is popped without a push; a pair of terminators yields one pushed terminator.
   assign a_rd = !i_rst && ((merge_go && (a_term || (!b_term && a_first))) || drain_a_go);
   assign b_rd = !i_rst && ((merge_go && (b_term || (!a_term && !a_first))) || drain_b_go);
   assign wr   = !i_rst && ((merge_go && (a_term == b_term)) || drain_a_go || drain_b_go || flush_go);
   assign item = !wr ? '0 : a_rd ? bus.a_item : b_rd ? bus.b_item : '0;
   assign push_data = wr && item != '0;
   assign bus.a_read = a_rd;
   assign bus.b_read = b_rd;
   assign bus.write  = wr;
   assign bus.item   = item;
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.count  = count;
   // Sequencer state plus registered busy/done/count
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
      end else begin
         done <= 1'b0;
         if (push_data) count <= count + COUNT_WIDTH'(1);
         case (state)
            IDLE: if (bus.start) begin
               state <= MERGE;
               busy  <= 1'b1;
               count <= '0;
            end
            MERGE: if (merge_go && a_term) begin
               state <= b_term ? DONE : DRAIN_B;
               done  <= b_term;
            end else if (merge_go && b_term) state <= DRAIN_A;
            DRAIN_A: if (drain_a_go && a_term) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DRAIN_B: if (drain_b_go && b_term) begin
               state <= DONE;
               done  <= 1'b1;
            end
            FLUSH: if (flush_go) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
